// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with per-digit blink and decimal point.
// All pin outputs are registered and reloaded only on a refresh wrap, so each slot is glitch-free.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [1:0]    idx;

    logic          refresh_wrap;
    logic          blink_wrap;
    logic          phase_next;
    logic [1:0]    idx_next;
    logic [3:0]    sel_digit;
    logic          sel_blink;
    logic          sel_dp;
    logic          slot_blank;

    function automatic logic [6:0] decode_bcd(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // The slot loaded on a wrap uses the incoming idx and the post-toggle blink phase.
    always_comb begin
        refresh_wrap = en && (refresh_cnt == REFRESH_LAST);
        blink_wrap   = en && (blink_cnt == BLINK_LAST);
        phase_next   = blink_phase ^ blink_wrap;
        idx_next     = idx + 2'd1;
        sel_digit    = digit0;
        case (idx_next)
            2'd0: sel_digit = digit0;
            2'd1: sel_digit = digit1;
            2'd2: sel_digit = digit2;
            2'd3: sel_digit = digit3;
            default: sel_digit = digit0;
        endcase
        sel_blink  = blink_mask[idx_next];
        sel_dp     = dp_in[idx_next];
        slot_blank = phase_next && sel_blink;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            idx         <= 2'd3;
            an          <= '1;
            seg         <= '1;
            dp          <= 1'b1;
        end else if (!en) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RW'(1);
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink_phase <= phase_next;
            if (refresh_wrap) begin
                idx <= idx_next;
                if (slot_blank) begin
                    an  <= '1;
                    seg <= '1;
                    dp  <= 1'b1;
                end else begin
                    an  <= ~(4'b0001 << idx_next);
                    seg <= decode_bcd(sel_digit);
                    dp  <= ~sel_dp;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vectors, corner sequences and randomized
// stimulus against an arithmetic model based on the count of enabled edges since reset.
module tb_seg7_scan_driver;

    localparam int R = 4;
    localparam int B = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] blink_mask;
    logic [3:0] dp_in;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks   = 0;
    int failures = 0;

    // Model state: enabled edges since reset, last loaded slot, expected pins.
    int         m_n;
    int         m_idx;
    bit         m_loaded;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                                 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

    typedef struct {
        logic [3:0] val;
        logic       dpb;
        logic [6:0] exp_seg;
        logic       exp_dp;
    } vec_t;

    vec_t vecs [16];

    seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .blink_mask (blink_mask),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        if (an !== ea || seg !== es || dp !== ed) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: cycle budget expired at edge %0d", name, m_n);
    endtask

    task automatic model_reset();
        m_n      = 0;
        m_idx    = 3;
        m_loaded = 0;
        m_an     = 4'b1111;
        m_seg    = 7'b1111111;
        m_dp     = 1'b1;
    endtask

    task automatic tick();
        logic       r, e;
        logic [3:0] d [4];
        logic [3:0] mk, dpi;
        int         ph;
        r = rst; e = en; mk = blink_mask; dpi = dp_in;
        d[0] = digit0; d[1] = digit1; d[2] = digit2; d[3] = digit3;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (!e) begin
            m_loaded = 0;
            m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
        end else begin
            m_n++;
            m_loaded = 0;
            if (m_n % R == 0) begin
                m_idx    = ((m_n / R) - 1) % 4;
                ph       = (m_n / B) % 2;
                m_loaded = 1;
                if (ph == 1 && mk[m_idx]) begin
                    m_an = 4'b1111; m_seg = 7'b1111111; m_dp = 1'b1;
                end else begin
                    m_an  = ~(4'b0001 << m_idx);
                    m_seg = seg_tab[d[m_idx]];
                    m_dp  = ~dpi[m_idx];
                end
            end
        end
        #1;
        check("model", m_an, m_seg, m_dp);
    endtask

    task automatic run_to(input int target);
        int unsigned g = 0;
        while (m_n < target && g < 200) begin
            tick();
            g++;
        end
        if (m_n != target) bound_fail("run_to");
    endtask

    task automatic run_to_slot(input int k);
        int unsigned g = 0;
        tick();
        while (!(m_loaded && m_idx == k) && g < 40) begin
            tick();
            g++;
        end
        if (!(m_loaded && m_idx == k)) bound_fail("run_to_slot");
    endtask

    task automatic first_slot_seq();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("first_blank", 4'b1111, 7'b1111111, 1'b1);
        end
        tick();
        check("first_s0", 4'b1110, 7'b0011001, 1'b1);
        run_to(8);
        check("first_s1", 4'b1101, 7'b0100100, 1'b1);
        run_to(12);
        check("first_s2", 4'b1011, 7'b0110000, 1'b1);
        run_to(16);
        check("first_s3", 4'b0111, 7'b1111001, 1'b1);
        run_to(20);
        check("first_wrap", 4'b1110, 7'b0011001, 1'b1);
    endtask

    task automatic set_defaults();
        digit0 = 4'd4; digit1 = 4'd2; digit2 = 4'd3; digit3 = 4'd1;
        blink_mask = 4'b0000; dp_in = 4'b0000; en = 1'b1;
    endtask

    initial begin
        vecs = '{'{4'd0,  1'b0, 7'b1000000, 1'b1}, '{4'd1,  1'b1, 7'b1111001, 1'b0},
                 '{4'd2,  1'b0, 7'b0100100, 1'b1}, '{4'd3,  1'b1, 7'b0110000, 1'b0},
                 '{4'd4,  1'b0, 7'b0011001, 1'b1}, '{4'd5,  1'b1, 7'b0010010, 1'b0},
                 '{4'd6,  1'b0, 7'b0000010, 1'b1}, '{4'd7,  1'b1, 7'b1111000, 1'b0},
                 '{4'd8,  1'b0, 7'b0000000, 1'b1}, '{4'd9,  1'b1, 7'b0010000, 1'b0},
                 '{4'd10, 1'b0, 7'b1111111, 1'b1}, '{4'd11, 1'b1, 7'b1111111, 1'b0},
                 '{4'd12, 1'b0, 7'b1111111, 1'b1}, '{4'd13, 1'b1, 7'b1111111, 1'b0},
                 '{4'd14, 1'b0, 7'b1111111, 1'b1}, '{4'd15, 1'b1, 7'b1111111, 1'b0}};

        rst = 1'b0;
        set_defaults();
        model_reset();
        tick();
        tick();
        check("reset_state", 4'b1111, 7'b1111111, 1'b1);
        rst = 1'b1;
        first_slot_seq();

        // Mid-slot input change must not reach the pins until the next slot-0 load.
        tick();
        tick();
        digit0 = 4'd7;
        tick();
        check("midslot_hold", 4'b1110, 7'b0011001, 1'b1);
        run_to_slot(0);
        check("midslot_new", 4'b1110, 7'b1111000, 1'b1);

        for (int i = 0; i < 16; i++) begin
            digit0   = vecs[i].val;
            dp_in[0] = vecs[i].dpb;
            run_to_slot(0);
            check("decode_vec", 4'b1110, vecs[i].exp_seg, vecs[i].exp_dp);
        end
        set_defaults();

        digit2 = 4'd12;
        dp_in  = 4'b0100;
        run_to_slot(2);
        check("invalid_bcd_s2", 4'b1011, 7'b1111111, 1'b0);
        run_to_slot(3);
        check("dp_off_s3", 4'b0111, 7'b1111001, 1'b1);
        set_defaults();

        run_to_slot(0);
        tick();
        en = 1'b0;
        tick();
        check("en_blank", 4'b1111, 7'b1111111, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        en = 1'b1;
        tick();
        tick();
        check("en_wait", 4'b1111, 7'b1111111, 1'b1);
        tick();
        check("en_resume", 4'b1101, 7'b0100100, 1'b1);

        // Fresh reset so blink phases line up with absolute edge numbers.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        blink_mask = 4'b0011;
        run_to(20);
        check("blink_s0_off", 4'b1111, 7'b1111111, 1'b1);
        run_to(24);
        check("blink_s1_off", 4'b1111, 7'b1111111, 1'b1);
        run_to(28);
        check("blink_s2_lit", 4'b1011, 7'b0110000, 1'b1);
        run_to(36);
        check("blink_s0_on", 4'b1110, 7'b0011001, 1'b1);
        blink_mask = 4'b1000;
        run_to(48);
        check("coincide_blank", 4'b1111, 7'b1111111, 1'b1);
        run_to(64);
        check("coincide_lit", 4'b0111, 7'b1111001, 1'b1);
        set_defaults();

        run_to_slot(2);
        tick();
        #2 rst = 1'b0;
        #1 model_reset();
        check("async_blank", 4'b1111, 7'b1111111, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        first_slot_seq();

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0: digit0     = 4'($urandom_range(0, 15));
                1: digit1     = 4'($urandom_range(0, 15));
                2: digit2     = 4'($urandom_range(0, 15));
                3: digit3     = 4'($urandom_range(0, 15));
                4: blink_mask = 4'($urandom_range(0, 15));
                5: dp_in      = 4'($urandom_range(0, 15));
                6: if ($urandom_range(0, 3) == 0) en = ~en;
                default: ;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                #1 model_reset();
                check("rand_async", 4'b1111, 7'b1111111, 1'b1);
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
